// File: rtl/key_scan_pkg.sv
// Shared encodings and default timing for the board I/O serial paths
// (LED shift-out and key scan-in).
package key_scan_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOAD    = 3'd1,
      ST_SHIFT_L = 3'd2,
      ST_SHIFT_H = 3'd3,
      ST_DONE    = 3'd4
   } scan_state_e;

   typedef enum logic [1:0] {
      LED_OFF   = 2'd0,
      LED_ON    = 2'd1,
      LED_BLINK = 2'd2,
      LED_PWM   = 2'd3
   } led_mode_e;

   localparam int unsigned DEF_NBIT     = 8;
   localparam int unsigned DEF_CLK_DIV  = 4;
   localparam int unsigned DEF_POLL_MAX = 32'h0098_9680;
   localparam int unsigned DEF_DEB_CNT  = 3;

endpackage

// File: rtl/key_shift.sv
// Drives a 74HC165 chain (parallel load, then MSB-first shift) and captures
// one NBIT word per start request.
module key_shift
   import key_scan_pkg::*;
#(
   parameter int unsigned NBIT    = DEF_NBIT,
   parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            sft_q7,
   output logic            sft_pl,
   output logic            sft_cp,
   output logic [NBIT-1:0] raw,
   output logic            scan_done,
   output logic            busy
);

   localparam int unsigned PH_W  = $clog2(2 * CLK_DIV);
   localparam int unsigned BIT_W = (NBIT > 1) ? $clog2(NBIT) : 1;
   localparam logic [PH_W-1:0]  LOAD_LAST = PH_W'(2 * CLK_DIV - 1);
   localparam logic [PH_W-1:0]  HALF_LAST = PH_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(NBIT - 1);

   scan_state_e     state_q, state_d;
   logic [PH_W-1:0] phase_q, phase_d;
   logic [BIT_W-1:0] bit_q, bit_d;
   logic [NBIT-1:0] shreg_q, shreg_d;
   logic [NBIT-1:0] raw_q, raw_d;
   logic            done_q, done_d;
   logic            busy_q, busy_d;
   logic            pl_q, pl_d;
   logic            cp_q, cp_d;

   // Next state; pin levels are derived from the next state so they are
   // registered alongside it and only move on state boundaries.
   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      bit_d   = bit_q;
      shreg_d = shreg_q;
      raw_d   = raw_q;
      done_d  = 1'b0;
      busy_d  = busy_q;
      pl_d    = pl_q;
      cp_d    = cp_q;

      unique case (state_q)
         ST_IDLE: begin
            phase_d = '0;
            bit_d   = '0;
            if (start) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            if (phase_q == LOAD_LAST) begin
               phase_d = '0;
               state_d = ST_SHIFT_L;
            end else begin
               phase_d = phase_q + PH_W'(1);
            end
         end
         ST_SHIFT_L: begin
            if (phase_q == HALF_LAST) begin
               phase_d = '0;
               shreg_d = {shreg_q[NBIT-2:0], sft_q7};
               state_d = ST_SHIFT_H;
            end else begin
               phase_d = phase_q + PH_W'(1);
            end
         end
         ST_SHIFT_H: begin
            if (phase_q == HALF_LAST) begin
               phase_d = '0;
               if (bit_q == BIT_LAST) begin
                  raw_d   = shreg_q;
                  done_d  = 1'b1;
                  state_d = ST_DONE;
               end else begin
                  bit_d   = bit_q + BIT_W'(1);
                  state_d = ST_SHIFT_L;
               end
            end else begin
               phase_d = phase_q + PH_W'(1);
            end
         end
         ST_DONE: begin
            bit_d   = '0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d != ST_IDLE);
      pl_d   = (state_d != ST_LOAD);
      cp_d   = (state_d == ST_SHIFT_H);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         phase_q <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         raw_q   <= '0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         pl_q    <= 1'b1;
         cp_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
         raw_q   <= raw_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         pl_q    <= pl_d;
         cp_q    <= cp_d;
      end
   end

   assign sft_pl    = pl_q;
   assign sft_cp    = cp_q;
   assign raw       = raw_q;
   assign scan_done = done_q;
   assign busy      = busy_q;

endmodule

// File: rtl/key_scan.sv
// Periodic / on-demand key scanner: poll timer, 165 scan engine and a
// consecutive-match debouncer producing a stable word and change pulse.
module key_scan
   import key_scan_pkg::*;
#(
   parameter int unsigned NBIT     = DEF_NBIT,
   parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
   parameter int unsigned POLL_MAX = DEF_POLL_MAX,
   parameter int unsigned DEB_CNT  = DEF_DEB_CNT
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req,
   input  logic            poll_en,
   output logic            sft_pl,
   output logic            sft_cp,
   input  logic            sft_q7,
   output logic [NBIT-1:0] raw,
   output logic            scan_done,
   output logic [NBIT-1:0] dout,
   output logic            chg,
   output logic            busy
);

   localparam int unsigned POLL_W = $clog2(POLL_MAX + 1);
   localparam int unsigned CNT_W  = $clog2(DEB_CNT + 1);
   localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_MAX - 1);
   localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEB_CNT);

   logic [POLL_W-1:0] poll_q, poll_d;
   logic [NBIT-1:0]   raw_prev_q, raw_prev_d;
   logic [CNT_W-1:0]  same_q, same_d;
   logic [NBIT-1:0]   dout_q, dout_d;
   logic              chg_q, chg_d;
   logic              poll_tick;
   logic              start;

   key_shift #(
      .NBIT    (NBIT),
      .CLK_DIV (CLK_DIV)
   ) u_shift (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .sft_q7    (sft_q7),
      .sft_pl    (sft_pl),
      .sft_cp    (sft_cp),
      .raw       (raw),
      .scan_done (scan_done),
      .busy      (busy)
   );

   // Requests arriving while a scan is running are dropped, not queued.
   always_comb begin
      poll_tick = poll_en && (poll_q == POLL_LAST);
      start     = !busy && (req || poll_tick);
      if (!poll_en || poll_tick) poll_d = '0;
      else                       poll_d = poll_q + POLL_W'(1);
   end

   // Debounce runs in the DONE cycle, when raw already holds the new word.
   always_comb begin
      raw_prev_d = raw_prev_q;
      same_d     = same_q;
      dout_d     = dout_q;
      chg_d      = 1'b0;
      if (scan_done) begin
         raw_prev_d = raw;
         if (raw == raw_prev_q) same_d = (same_q == CNT_FULL) ? same_q : same_q + CNT_W'(1);
         else                   same_d = CNT_W'(1);
         if ((same_d == CNT_FULL) && (raw != dout_q)) begin
            dout_d = raw;
            chg_d  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         poll_q     <= '0;
         raw_prev_q <= '0;
         same_q     <= '0;
         dout_q     <= '0;
         chg_q      <= 1'b0;
      end else begin
         poll_q     <= poll_d;
         raw_prev_q <= raw_prev_d;
         same_q     <= same_d;
         dout_q     <= dout_d;
         chg_q      <= chg_d;
      end
   end

   assign dout = dout_q;
   assign chg  = chg_q;

endmodule

// File: tb/tb_key_scan.sv
// Bench for key_scan: 165 chain model, table-driven scan/debounce vectors
// and directed sequences for polling, dropped requests, reset and a 16-bit build.
module tb_key_scan;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, req_a, poll_en_a, req_b, poll_en_b;
   logic [7:0]  pins_a;
   logic [15:0] pins_b;

   logic        sft_pl_a, sft_cp_a, sft_q7_a, scan_done_a, chg_a, busy_a;
   logic [7:0]  raw_a, dout_a;
   logic        sft_pl_b, sft_cp_b, sft_q7_b, scan_done_b, chg_b, busy_b;
   logic [15:0] raw_b, dout_b;

   key_scan #(.NBIT(8), .CLK_DIV(4), .POLL_MAX(200), .DEB_CNT(3)) dut_a (
      .clk(clk), .rst(rst), .req(req_a), .poll_en(poll_en_a),
      .sft_pl(sft_pl_a), .sft_cp(sft_cp_a), .sft_q7(sft_q7_a),
      .raw(raw_a), .scan_done(scan_done_a), .dout(dout_a), .chg(chg_a), .busy(busy_a));

   key_scan #(.NBIT(16), .CLK_DIV(2), .POLL_MAX(200), .DEB_CNT(3)) dut_b (
      .clk(clk), .rst(rst), .req(req_b), .poll_en(poll_en_b),
      .sft_pl(sft_pl_b), .sft_cp(sft_cp_b), .sft_q7(sft_q7_b),
      .raw(raw_b), .scan_done(scan_done_b), .dout(dout_b), .chg(chg_b), .busy(busy_b));

   // 165 chain models: load while PL low, shift on CP rise, Q7 = MSB.
   logic [7:0]  sr_a;
   logic [15:0] sr_b;
   logic        cpp_a, cpp_b;
   always_ff @(posedge clk) begin
      cpp_a <= sft_cp_a;
      cpp_b <= sft_cp_b;
      if (!sft_pl_a) sr_a <= pins_a;
      else if (sft_cp_a && !cpp_a) sr_a <= {sr_a[6:0], 1'b0};
      if (!sft_pl_b) sr_b <= pins_b;
      else if (sft_cp_b && !cpp_b) sr_b <= {sr_b[14:0], 1'b0};
   end
   assign sft_q7_a = sr_a[7];
   assign sft_q7_b = sr_b[15];

   int nassert = 0;
   int nfail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nassert++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; req_a = 1'b0; req_b = 1'b0; poll_en_a = 1'b0; poll_en_b = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_pl", 32'(sft_pl_a), 32'd1);
      chk("rst_cp", 32'(sft_cp_a), 32'd0);
      chk("rst_raw", 32'(raw_a), 32'd0);
      chk("rst_dout", 32'(dout_a), 32'd0);
      chk("rst_flags", {29'd0, scan_done_a, chg_a, busy_a}, 32'd0);
      rst = 1'b0;
   endtask

   // Scan measurements
   int          m_lat, m_pl_low, m_cp_rise, m_cp_high, m_busy_low;
   logic [15:0] m_raw, m_dout;
   logic        m_chg1, m_chg2, m_done2;

   task automatic run_scan(input bit sel, input logic [15:0] data);
      logic pl, cp, bz, dn, prev_cp;
      if (sel) begin pins_b = data; req_b = 1'b1; end
      else     begin pins_a = data[7:0]; req_a = 1'b1; end
      @(negedge clk);
      req_a = 1'b0; req_b = 1'b0;
      m_lat = 0; m_pl_low = 0; m_cp_rise = 0; m_cp_high = 0; m_busy_low = 0;
      prev_cp = 1'b0;
      for (int i = 1; i <= 300; i++) begin
         pl = sel ? sft_pl_b : sft_pl_a;
         cp = sel ? sft_cp_b : sft_cp_a;
         bz = sel ? busy_b : busy_a;
         dn = sel ? scan_done_b : scan_done_a;
         if (!pl) m_pl_low++;
         if (cp) m_cp_high++;
         if (cp && !prev_cp) m_cp_rise++;
         if (!bz) m_busy_low++;
         prev_cp = cp;
         if (dn) begin m_lat = i; break; end
         @(negedge clk);
      end
      m_raw = sel ? raw_b : {8'd0, raw_a};
      @(negedge clk);
      m_chg1  = sel ? chg_b : chg_a;
      m_done2 = sel ? scan_done_b : scan_done_a;
      m_dout  = sel ? dout_b : {8'd0, dout_a};
      @(negedge clk);
      m_chg2  = sel ? chg_b : chg_a;
   endtask

   typedef struct {
      bit         rst_first;
      logic [7:0] pins;
      logic [7:0] exp_raw;
      logic [7:0] exp_dout;
      bit         exp_chg;
   } vec_t;

   vec_t vecs[12];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; req_a = 1'b0; req_b = 1'b0; poll_en_a = 1'b0; poll_en_b = 1'b0;
      pins_a = 8'h00; pins_b = 16'h0000;

      vecs[0]  = '{1'b1, 8'hA5, 8'hA5, 8'h00, 1'b0};
      vecs[1]  = '{1'b0, 8'hA5, 8'hA5, 8'h00, 1'b0};
      vecs[2]  = '{1'b0, 8'hA5, 8'hA5, 8'hA5, 1'b1};
      vecs[3]  = '{1'b0, 8'hA5, 8'hA5, 8'hA5, 1'b0};
      vecs[4]  = '{1'b1, 8'h01, 8'h01, 8'h00, 1'b0};
      vecs[5]  = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b0};
      vecs[6]  = '{1'b0, 8'h01, 8'h01, 8'h00, 1'b0};
      vecs[7]  = '{1'b0, 8'h01, 8'h01, 8'h00, 1'b0};
      vecs[8]  = '{1'b0, 8'h01, 8'h01, 8'h01, 1'b1};
      vecs[9]  = '{1'b0, 8'hFF, 8'hFF, 8'h01, 1'b0};
      vecs[10] = '{1'b0, 8'hFF, 8'hFF, 8'h01, 1'b0};
      vecs[11] = '{1'b0, 8'hFF, 8'hFF, 8'hFF, 1'b1};

      // Scans on request with debounce sequences
      for (int v = 0; v < 12; v++) begin
         if (vecs[v].rst_first) do_reset();
         run_scan(1'b0, {8'd0, vecs[v].pins});
         chk($sformatf("v%0d_latency", v), 32'(m_lat), 32'd73);
         chk($sformatf("v%0d_raw", v), 32'(m_raw), 32'(vecs[v].exp_raw));
         chk($sformatf("v%0d_dout", v), 32'(m_dout), 32'(vecs[v].exp_dout));
         chk($sformatf("v%0d_chg", v), 32'(m_chg1), 32'(vecs[v].exp_chg));
         chk($sformatf("v%0d_chg_width", v), 32'(m_chg2), 32'd0);
         chk($sformatf("v%0d_done_width", v), 32'(m_done2), 32'd0);
         chk($sformatf("v%0d_pl_low", v), 32'(m_pl_low), 32'd8);
         chk($sformatf("v%0d_cp_rise", v), 32'(m_cp_rise), 32'd8);
         chk($sformatf("v%0d_cp_high", v), 32'(m_cp_high), 32'd32);
         chk($sformatf("v%0d_busy_low", v), 32'(m_busy_low), 32'd0);
      end

      // Reset in the middle of SHIFT_L bit 4 (cycles 41..44 of the scan)
      begin
         pins_a = 8'h5A;
         req_a  = 1'b1;
         @(negedge clk);
         req_a = 1'b0;
         repeat (41) @(negedge clk);
         chk("abort_pre_cp", 32'(sft_cp_a), 32'd0);
         chk("abort_pre_busy", 32'(busy_a), 32'd1);
         rst = 1'b1;
         @(negedge clk);
         chk("abort_pl", 32'(sft_pl_a), 32'd1);
         chk("abort_cp", 32'(sft_cp_a), 32'd0);
         chk("abort_busy", 32'(busy_a), 32'd0);
         chk("abort_raw", 32'(raw_a), 32'd0);
         chk("abort_dout", 32'(dout_a), 32'd0);
         rst = 1'b0;
         @(negedge clk);
         run_scan(1'b0, 16'h005A);
         chk("abort_rescan_lat", 32'(m_lat), 32'd73);
         chk("abort_rescan_raw", 32'(m_raw), 32'h5A);
         chk("abort_rescan_dout", 32'(m_dout), 32'd0);
      end

      // Auto polling every 200 cycles, steady 8'h3C
      begin
         int n_done, first_done, last_done, n_chg, chg_cyc;
         logic [7:0] dout_2nd;
         do_reset();
         pins_a = 8'h3C; poll_en_a = 1'b1;
         n_done = 0; first_done = 0; last_done = 0; n_chg = 0; chg_cyc = 0; dout_2nd = 8'hXX;
         for (int c = 1; c <= 1000; c++) begin
            @(negedge clk);
            if (scan_done_a) begin
               n_done++;
               if (n_done == 1) first_done = c;
               last_done = c;
            end
            if (chg_a) begin n_chg++; chg_cyc = c; end
            if (c == 473) dout_2nd = dout_a;
         end
         poll_en_a = 1'b0;
         chk("poll_n_scans", 32'(n_done), 32'd4);
         chk("poll_first_done", 32'(first_done), 32'd272);
         chk("poll_last_done", 32'(last_done), 32'd872);
         chk("poll_n_chg", 32'(n_chg), 32'd1);
         chk("poll_chg_cycle", 32'(chg_cyc), 32'd673);
         chk("poll_dout_after2", 32'(dout_2nd), 32'd0);
         chk("poll_dout_final", 32'(dout_a), 32'h3C);
      end

      // req coincident with poll tick, then req during SHIFT_H: both one scan
      begin
         int n_done, d1, d2, busy_hi1, busy_hi2;
         bit pulsed, clr;
         do_reset();
         pins_a = 8'h81; poll_en_a = 1'b1;
         repeat (199) @(negedge clk);
         req_a = 1'b1;
         n_done = 0; d1 = 0; d2 = 0; busy_hi1 = 0; busy_hi2 = 0; pulsed = 1'b0; clr = 1'b0;
         for (int c = 1; c <= 280; c++) begin
            @(negedge clk);
            if (c == 1 || clr) begin req_a = 1'b0; clr = 1'b0; end
            if (sft_cp_a && !pulsed) begin req_a = 1'b1; pulsed = 1'b1; clr = 1'b1; end
            if (scan_done_a) begin
               n_done++;
               if (n_done == 1) d1 = c;
               if (n_done == 2) d2 = c;
            end
            if (busy_a && c <= 73) busy_hi1++;
            if (busy_a && c >= 74 && c <= 200) busy_hi2++;
         end
         poll_en_a = 1'b0;
         chk("drop_n_scans", 32'(n_done), 32'd2);
         chk("drop_first_done", 32'(d1), 32'd73);
         chk("drop_second_done", 32'(d2), 32'd273);
         chk("drop_busy_during", 32'(busy_hi1), 32'd73);
         chk("drop_busy_after", 32'(busy_hi2), 32'd0);
         chk("drop_raw", 32'(raw_a), 32'h81);
      end

      // 16-bit chain at CLK_DIV=2
      do_reset();
      run_scan(1'b1, 16'hBEEF);
      chk("w16_latency", 32'(m_lat), 32'd69);
      chk("w16_raw", 32'(m_raw), 32'hBEEF);
      chk("w16_pl_low", 32'(m_pl_low), 32'd4);
      chk("w16_cp_rise", 32'(m_cp_rise), 32'd16);
      chk("w16_cp_high", 32'(m_cp_high), 32'd32);
      chk("w16_dout", 32'(m_dout), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
      $finish;
   end

endmodule
